mem_arbiter: RTL
================

# mem_arbiter

Sequencing controller and arbiter for the 16-word × 16-bit data memory in the Tomasulo datapath. It accepts load and store requests from `NREQ` load/store buffers and grants one request at a time by round-robin. It drives the memory's address, write and write-data lines for a fixed access window. Load results, tagged with the requesting buffer's tag, are broadcast on the CDB through a valid/ready handshake.

## Interface
- `NREQ`, 4: number of load/store buffers (≥2).
- `TAG_W`, 3: reservation tag width.
- `MEM_LAT`, 2: access window length in cycles (≥1).
- `clock` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `req` in NREQ: request per buffer; held until its `gnt` pulse.
- `req_we` in NREQ: 1 = store, 0 = load.
- `req_addr` in NREQ*4: word address, buffer i at bits [4i+3:4i].
- `req_data` in NREQ*16: store data, buffer i at bits [16i+15:16i].
- `req_tag` in NREQ*TAG_W: result tag per buffer.
- `gnt` out NREQ: one-cycle, one-hot acceptance pulse.
- `mem_addr` out 4: to memory `addr`.
- `mem_write` out 1: to memory `write`.
- `mem_wdata` out 16: to memory `datain`.
- `mem_rdata` in 16: from memory `dataout`.
- `cdb_valid` out 1: load result available.
- `cdb_tag` out TAG_W: tag of the result.
- `cdb_data` out 16: loaded word.
- `cdb_ready` in 1: CDB accepts the result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, BCAST.
- **IDLE:** if any `req` is high at an edge, the arbiter picks a winner, latches its we/addr/data/tag, loads the access counter with `MEM_LAT-1`, and moves to ACCESS. `gnt[winner]` is 1 in the following cycle.
- **Round-robin:** the search starts at `rr_ptr`. On a grant, `rr_ptr` becomes winner+1 modulo NREQ.
- **ACCESS:** `mem_addr` and `mem_wdata` hold the latched values. `mem_write` equals the latched we for all `MEM_LAT` cycles. The counter decrements each cycle.
  - When the counter is 0, a load captures `mem_rdata` into `cdb_data` and goes to BCAST.
  - When the counter is 0, a store goes directly to IDLE.
- **BCAST:** `cdb_valid`=1 and `cdb_tag`/`cdb_data` are held stable until an edge with `cdb_ready`=1, then the FSM returns to IDLE. Stalls are unbounded.
- `req` is ignored outside IDLE. A requester may drop `req` during its `gnt` cycle.
- `mem_write` is 0 in IDLE and BCAST. `mem_addr` keeps its last value.
- Reset mid-access aborts the operation. The memory write deasserts in the next cycle, and no CDB broadcast follows.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `gnt`=0, `mem_addr`=0, `mem_write`=0, `mem_wdata`=0, `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `busy`=0.
- With `req` sampled at edge 0:
  - `gnt` and ACCESS occupy cycle 1.
  - ACCESS runs for cycles 1..MEM_LAT.
  - For a load, `cdb_valid` rises in cycle MEM_LAT+1.
  - For a store, IDLE is re-entered in cycle MEM_LAT+1.
- Minimum issue interval: MEM_LAT+1 cycles for a store. For a load, MEM_LAT+2 cycles with `cdb_ready` tied high.

## Configuration
- `MEMARB_STORE_PRIO_EN` defined: if any requesting buffer has `req_we`=1, only store requests compete (round-robin among them). Loads are granted only when no store is pending. `rr_ptr` still updates on every grant.
- Undefined: pure round-robin over all requests, with no distinction between loads and stores.

## Structure
- Package `memarb_pkg`: `ADDR_W`=4, `DATA_W`=16, and a state enum `memarb_state_t` with values IDLE/ACCESS/BCAST.
- Sub-module `rr_arbiter`: combinational, parameterised on N. Inputs are a request vector and a pointer; output is a one-hot grant. Store priority is applied by masking its request input.

## Test plan
- Reset, then load `req[0]` addr 1 tag 5, `MEM_LAT`=2, `cdb_ready`=1. Expect `gnt[0]` in cycle 1, then `cdb_valid` with tag 5 and data 0x0003 in cycle 3.
- Store buffer 1 writes addr 2 data 0x00AA, then buffer 0 loads addr 2. Expect `mem_write` high for exactly 2 cycles, then a CDB result of 0x00AA.
- All four buffers load continuously from `rr_ptr`=0. Expect grant order 0, 1, 2, 3, 0.
- Load with `cdb_ready` held low for 5 cycles. Expect `cdb_valid`, tag and data stable throughout and no new grant until the handshake completes.
- With `MEMARB_STORE_PRIO_EN`, load on buffer 0 and store on buffer 2 raised together. Expect `gnt[2]` first. Without the macro, expect `gnt[0]` first.
- Assert `reset` during cycle 1 of a store's ACCESS. Expect `mem_write` 0 in the next cycle, `busy` 0, and no `cdb_valid`.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared widths and FSM state type for the Tomasulo data-memory arbiter.
package memarb_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        BCAST  = 2'd2
    } memarb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the lowest requester at or above ptr wins,
// otherwise the search wraps around to the lowest requester overall.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);
    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;
    logic [N-1:0] pick_req;

    assign upper_mask = ~((N'(1) << ptr) - N'(1));
    assign upper_req  = req & upper_mask;
    assign pick_req   = (|upper_req) ? upper_req : req;
    // Isolate the lowest set bit of the chosen half.
    assign grant      = pick_req & (~pick_req + N'(1));
endmodule

// File: rtl/mem_arbiter.sv
// Load/store sequencer for the 16x16 data memory with round-robin arbitration and CDB broadcast.
// Define MEMARB_STORE_PRIO_EN to let pending stores win over loads.
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TAG_W   = 3,
    parameter int MEM_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    output logic [NREQ-1:0]          gnt,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_write,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    input  logic                     cdb_ready,
    output logic                     busy
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];
    logic [TAG_W-1:0]  tag_arr  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
            assign tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
        end
    endgenerate

    memarb_state_t     state_reg;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic              we_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_write_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              cdb_valid_reg;
    logic [TAG_W-1:0]  cdb_tag_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic              busy_reg;

    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   grant;

`ifdef MEMARB_STORE_PRIO_EN
    logic [NREQ-1:0]   store_req;
    assign store_req = req & req_we;
    assign arb_req   = (|store_req) ? store_req : req;
`else
    assign arb_req   = req;
`endif

    rr_arbiter #(.N(NREQ), .PTR_W(PTR_W)) u_rr (
        .req   (arb_req),
        .ptr   (rr_ptr_reg),
        .grant (grant)
    );

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_tag;
    logic [PTR_W-1:0]  next_ptr;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_tag  = '0;
        next_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_we   = req_we[i];
                sel_addr = addr_arr[i];
                sel_data = data_arr[i];
                sel_tag  = tag_arr[i];
                next_ptr = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            gnt_reg       <= '0;
            we_reg        <= 1'b0;
            tag_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_write_reg <= 1'b0;
            mem_wdata_reg <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_tag_reg   <= '0;
            cdb_data_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            gnt_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|arb_req) begin
                        state_reg     <= ACCESS;
                        busy_reg      <= 1'b1;
                        gnt_reg       <= grant;
                        rr_ptr_reg    <= next_ptr;
                        we_reg        <= sel_we;
                        tag_reg       <= sel_tag;
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_data;
                        mem_write_reg <= sel_we;
                        cnt_reg       <= CNT_W'(MEM_LAT - 1);
                    end
                end
                ACCESS: begin
                    if (cnt_reg == '0) begin
                        mem_write_reg <= 1'b0;
                        if (we_reg) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            // Read data is sampled on the last edge of the access window.
                            cdb_data_reg  <= mem_rdata;
                            cdb_tag_reg   <= tag_reg;
                            cdb_valid_reg <= 1'b1;
                            state_reg     <= BCAST;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                BCAST: begin
                    if (cdb_ready) begin
                        cdb_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_write = mem_write_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cdb_valid = cdb_valid_reg;
    assign cdb_tag   = cdb_tag_reg;
    assign cdb_data  = cdb_data_reg;
    assign busy      = busy_reg;
endmodule
